data_sram_ctrl: RTL and testbench



---
 rtl/data_sram_ctrl_pkg.sv | 19 +
 rtl/data_sram_ctrl.sv | 136 +++++++++++++
 tb/tb_data_sram_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_ctrl_pkg.sv
// Shared types for the data-side SRAM-like handshake controller.
// Holds the controller state encoding and the access-size codes.
package data_sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        DONE   = 3'd3,
        CANCEL = 3'd4
    } dsram_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } dsram_size_t;

endpackage

// File: rtl/data_sram_ctrl.sv
// Memory-stage to SRAM-like bus controller: issues each access once, captures load data.
// Latency: best case 2 stall cycles (addr_ok same cycle, data_ok next), released in DONE.
// Backpressure: m_stall holds the stage until data_ok; optional perf counters under DATA_SRAM_CTRL_PERF_EN.
module data_sram_ctrl
    import data_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef DATA_SRAM_CTRL_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_data_req,
    input  logic              m_data_wr,
    input  logic [1:0]        m_data_size,
    input  logic [ADDR_W-1:0] m_data_addr,
    input  logic [DATA_W-1:0] m_data_wdata,
    input  logic              flush,
    input  logic              ext_stall,
    output logic              m_stall,
    output logic [DATA_W-1:0] m_rdata,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
`ifdef DATA_SRAM_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_req_cnt,
    output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

    dsram_state_t state;
    logic         req_go;

    assign req_go = m_data_req && !flush;

    // The stage keeps these stable while stalled, so they go straight to the bus.
    assign data_wr    = m_data_wr;
    assign data_size  = m_data_size;
    assign data_addr  = m_data_addr;
    assign data_wdata = m_data_wdata;

    always_comb begin
        data_req = 1'b0;
        m_stall  = 1'b0;
        case (state)
            IDLE, ADDR: begin
                data_req = req_go;
                m_stall  = req_go;
            end
            DATA: begin
                m_stall = req_go;
            end
            CANCEL: begin
                // A killed access is still in flight; any new request must wait for it.
                m_stall = m_data_req;
            end
            default: begin
                data_req = 1'b0;
                m_stall  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            m_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_go) begin
                        state <= data_addr_ok ? DATA : ADDR;
                    end
                end
                ADDR: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (req_go && data_addr_ok) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (data_data_ok) begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            state   <= DONE;
                            m_rdata <= data_rdata;
                        end
                    end else if (flush) begin
                        state <= CANCEL;
                    end
                end
                DONE: begin
                    if (flush || !ext_stall) begin
                        state <= IDLE;
                    end
                end
                CANCEL: begin
                    if (data_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DATA_SRAM_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_req_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (data_req && data_addr_ok) begin
                perf_req_cnt <= perf_req_cnt + 1'b1;
            end
            if (m_stall) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: load/store handshakes, flush in ADDR/DATA, DONE hold.
module tb_data_sram_ctrl;
    import data_sram_ctrl_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int PERF_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              m_data_req;
    logic              m_data_wr;
    logic [1:0]        m_data_size;
    logic [ADDR_W-1:0] m_data_addr;
    logic [DATA_W-1:0] m_data_wdata;
    logic              flush;
    logic              ext_stall;
    logic              m_stall;
    logic [DATA_W-1:0] m_rdata;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
`ifdef DATA_SRAM_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_req_cnt;
    logic [PERF_W-1:0] perf_stall_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    data_sram_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
`ifdef DATA_SRAM_CTRL_PERF_EN
        ,
        .PERF_W(PERF_W)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_data_req   (m_data_req),
        .m_data_wr    (m_data_wr),
        .m_data_size  (m_data_size),
        .m_data_addr  (m_data_addr),
        .m_data_wdata (m_data_wdata),
        .flush        (flush),
        .ext_stall    (ext_stall),
        .m_stall      (m_stall),
        .m_rdata      (m_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
`ifdef DATA_SRAM_CTRL_PERF_EN
        ,
        .perf_req_cnt   (perf_req_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m_data_req   = 1'b0;
        m_data_wr    = 1'b0;
        m_data_size  = SZ_WORD;
        m_data_addr  = '0;
        m_data_wdata = '0;
        flush        = 1'b0;
        ext_stall    = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        #1;
        vectors++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
        vectors++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", m_rdata, 32'h0); end
        vectors++; if (m_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", m_stall); end
        vectors++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", data_req); end
        rst = 1'b0;
    endtask

    task automatic test_load_basic;
        cyc();
        m_data_req = 1'b1; m_data_wr = 1'b0; m_data_size = SZ_WORD;
        m_data_addr = 32'h8000_1000; data_addr_ok = 1'b1;
        #1;
        vectors++; if (m_stall !== 1'b1) begin errors++; $display("FAIL load_stall_t got=%b exp=1", m_stall); end
        vectors++; if (data_req !== 1'b1) begin errors++; $display("FAIL load_req_t got=%b exp=1", data_req); end
        vectors++; if (data_addr !== 32'h8000_1000) begin errors++; $display("FAIL load_addr got=%h exp=%h", data_addr, 32'h8000_1000); end
        cyc();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        #1;
        vectors++; if (m_stall !== 1'b1) begin errors++; $display("FAIL load_stall_t1 got=%b exp=1", m_stall); end
        vectors++; if (data_req !== 1'b0) begin errors++; $display("FAIL load_req_t1 got=%b exp=0", data_req); end
        vectors++; if (dut.state !== DATA) begin errors++; $display("FAIL load_state_t1 got=%0d exp=%0d", dut.state, DATA); end
        cyc();
        data_data_ok = 1'b0; data_rdata = '0;
        #1;
        vectors++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata_t2 got=%h exp=%h", m_rdata, 32'hDEAD_BEEF); end
        vectors++; if (m_stall !== 1'b0) begin errors++; $display("FAIL load_stall_t2 got=%b exp=0", m_stall); end
        vectors++; if (dut.state !== DONE) begin errors++; $display("FAIL load_state_t2 got=%0d exp=%0d", dut.state, DONE); end
        cyc();
        m_data_req = 1'b0;
        #1;
        vectors++; if (dut.state !== IDLE) begin errors++; $display("FAIL load_state_t3 got=%0d exp=%0d", dut.state, IDLE); end
        vectors++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata_t3 got=%h exp=%h", m_rdata, 32'hDEAD_BEEF); end
    endtask

    task automatic test_flush_addr;
        cyc();
        m_data_req = 1'b1; m_data_addr = 32'h8000_1100; data_addr_ok = 1'b0;
        #1;
        vectors++; if (data_req !== 1'b1) begin errors++; $display("FAIL faddr_req0 got=%b exp=1", data_req); end
        cyc();
        flush = 1'b1;
        #1;
        vectors++; if (dut.state !== ADDR) begin errors++; $display("FAIL faddr_state got=%0d exp=%0d", dut.state, ADDR); end
        vectors++; if (data_req !== 1'b0) begin errors++; $display("FAIL faddr_req_drop got=%b exp=0", data_req); end
        vectors++; if (m_stall !== 1'b0) begin errors++; $display("FAIL faddr_stall got=%b exp=0", m_stall); end
        cyc();
        flush = 1'b0; m_data_req = 1'b0;
        #1;
        vectors++; if (dut.state !== IDLE) begin errors++; $display("FAIL faddr_idle got=%0d exp=%0d", dut.state, IDLE); end
    endtask

    task automatic test_flush_data;
        cyc();
        m_data_req = 1'b1; m_data_wr = 1'b0; m_data_addr = 32'h8000_1200; data_addr_ok = 1'b1;
        #1;
        cyc();
        data_addr_ok = 1'b0; flush = 1'b1;
        #1;
        vectors++; if (dut.state !== DATA) begin errors++; $display("FAIL fdata_state got=%0d exp=%0d", dut.state, DATA); end
        vectors++; if (data_req !== 1'b0) begin errors++; $display("FAIL fdata_req got=%b exp=0", data_req); end
        cyc();
        flush = 1'b0; m_data_addr = 32'h8000_3000;
        #1;
        vectors++; if (dut.state !== CANCEL) begin errors++; $display("FAIL fdata_cancel got=%0d exp=%0d", dut.state, CANCEL); end
        vectors++; if (data_req !== 1'b0) begin errors++; $display("FAIL fdata_noissue got=%b exp=0", data_req); end
        vectors++; if (m_stall !== 1'b1) begin errors++; $display("FAIL fdata_stall got=%b exp=1", m_stall); end
        cyc();
        data_data_ok = 1'b1; data_rdata = 32'hAAAA_5555;
        #1;
        vectors++; if (data_req !== 1'b0) begin errors++; $display("FAIL fdata_noissue2 got=%b exp=0", data_req); end
        vectors++; if (m_stall !== 1'b1) begin errors++; $display("FAIL fdata_stall2 got=%b exp=1", m_stall); end
        cyc();
        data_data_ok = 1'b0; data_rdata = '0; data_addr_ok = 1'b1;
        #1;
        vectors++; if (dut.state !== IDLE) begin errors++; $display("FAIL fdata_idle got=%0d exp=%0d", dut.state, IDLE); end
        vectors++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fdata_rdata_kept got=%h exp=%h", m_rdata, 32'hDEAD_BEEF); end
        vectors++; if (data_req !== 1'b1) begin errors++; $display("FAIL fdata_reissue got=%b exp=1", data_req); end
        vectors++; if (data_addr !== 32'h8000_3000) begin errors++; $display("FAIL fdata_newaddr got=%h exp=%h", data_addr, 32'h8000_3000); end
        cyc();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
        #1;
        cyc();
        data_data_ok = 1'b0; data_rdata = '0;
        #1;
        vectors++; if (m_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL fdata_newload got=%h exp=%h", m_rdata, 32'h0BAD_F00D); end
        vectors++; if (dut.state !== DONE) begin errors++; $display("FAIL fdata_done got=%0d exp=%0d", dut.state, DONE); end
        cyc();
        m_data_req = 1'b0;
        #1;
    endtask

    task automatic test_store_wait;
        int nreq;
        int nacc;
        nreq = 0;
        nacc = 0;
        cyc();
        m_data_req = 1'b1; m_data_wr = 1'b1; m_data_size = SZ_WORD;
        m_data_addr = 32'h8000_2004; m_data_wdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            #1;
            if (data_req) nreq++;
            if (data_req && data_addr_ok) nacc++;
            vectors++; if (data_addr !== 32'h8000_2004) begin errors++; $display("FAIL store_addr[%0d] got=%h exp=%h", i, data_addr, 32'h8000_2004); end
            vectors++; if (data_wdata !== 32'h1234_5678 || data_wr !== 1'b1) begin errors++; $display("FAIL store_wdata[%0d] got=%h/%b exp=%h/1", i, data_wdata, data_wr, 32'h1234_5678); end
            cyc();
        end
        data_addr_ok = 1'b0;
        #1;
        if (data_req) nreq++;
        vectors++; if (dut.state !== DATA) begin errors++; $display("FAIL store_state got=%0d exp=%0d", dut.state, DATA); end
        cyc();
        data_data_ok = 1'b1;
        #1;
        if (data_req) nreq++;
        vectors++; if (m_stall !== 1'b1) begin errors++; $display("FAIL store_stall_ok got=%b exp=1", m_stall); end
        cyc();
        data_data_ok = 1'b0;
        #1;
        vectors++; if (m_stall !== 1'b0) begin errors++; $display("FAIL store_release got=%b exp=0", m_stall); end
        vectors++; if (nreq !== 4) begin errors++; $display("FAIL store_req_cycles got=%0d exp=4", nreq); end
        vectors++; if (nacc !== 1) begin errors++; $display("FAIL store_accepts got=%0d exp=1", nacc); end
        cyc();
        m_data_req = 1'b0; m_data_wr = 1'b0;
        #1;
        vectors++; if (dut.state !== IDLE) begin errors++; $display("FAIL store_idle got=%0d exp=%0d", dut.state, IDLE); end
    endtask

    task automatic test_done_hold;
        cyc();
        m_data_req = 1'b1; m_data_wr = 1'b0; m_data_addr = 32'h8000_4000; data_addr_ok = 1'b1;
        #1;
        cyc();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1357_9BDF;
        #1;
        cyc();
        data_data_ok = 1'b0; data_rdata = '0; ext_stall = 1'b1; data_addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (dut.state !== DONE) begin errors++; $display("FAIL hold_state[%0d] got=%0d exp=%0d", i, dut.state, DONE); end
            vectors++; if (data_req !== 1'b0) begin errors++; $display("FAIL hold_reissue[%0d] got=%b exp=0", i, data_req); end
            vectors++; if (m_stall !== 1'b0) begin errors++; $display("FAIL hold_stall[%0d] got=%b exp=0", i, m_stall); end
            vectors++; if (m_rdata !== 32'h1357_9BDF) begin errors++; $display("FAIL hold_rdata[%0d] got=%h exp=%h", i, m_rdata, 32'h1357_9BDF); end
            cyc();
        end
        ext_stall = 1'b0; data_addr_ok = 1'b0;
        #1;
        vectors++; if (dut.state !== DONE) begin errors++; $display("FAIL hold_last got=%0d exp=%0d", dut.state, DONE); end
        cyc();
        m_data_req = 1'b0;
        #1;
        vectors++; if (dut.state !== IDLE) begin errors++; $display("FAIL hold_idle got=%0d exp=%0d", dut.state, IDLE); end
        // Flush while held in DONE kills the instruction immediately.
        m_data_req = 1'b1; m_data_addr = 32'h8000_5000; data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h2468_ACE0;
        cyc();
        data_data_ok = 1'b0; ext_stall = 1'b1; flush = 1'b1;
        #1;
        vectors++; if (dut.state !== DONE) begin errors++; $display("FAIL dflush_done got=%0d exp=%0d", dut.state, DONE); end
        cyc();
        flush = 1'b0; ext_stall = 1'b0; m_data_req = 1'b0;
        #1;
        vectors++; if (dut.state !== IDLE) begin errors++; $display("FAIL dflush_idle got=%0d exp=%0d", dut.state, IDLE); end
        vectors++; if (m_rdata !== 32'h2468_ACE0) begin errors++; $display("FAIL dflush_rdata got=%h exp=%h", m_rdata, 32'h2468_ACE0); end
    endtask

`ifdef DATA_SRAM_CTRL_PERF_EN
    task automatic test_perf;
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        vectors++; if (perf_req_cnt !== '0 || perf_stall_cnt !== '0) begin errors++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_req_cnt, perf_stall_cnt); end
        for (int n = 0; n < 2; n++) begin
            cyc();
            m_data_req = 1'b1; m_data_addr = 32'h8000_6000 + 32'(n * 4); data_addr_ok = 1'b1;
            cyc();
            data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_1111;
            cyc();
            data_data_ok = 1'b0;
            cyc();
            m_data_req = 1'b0;
        end
        #1;
        vectors++; if (perf_req_cnt !== 32'd2) begin errors++; $display("FAIL perf_req got=%0d exp=2", perf_req_cnt); end
        vectors++; if (perf_stall_cnt !== 32'd4) begin errors++; $display("FAIL perf_stall got=%0d exp=4", perf_stall_cnt); end
        cyc();
        m_data_req = 1'b1; data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0; rst = 1'b1;
        #1;
        vectors++; if (dut.state !== DATA) begin errors++; $display("FAIL perf_midload got=%0d exp=%0d", dut.state, DATA); end
        cyc();
        rst = 1'b0; m_data_req = 1'b0;
        #1;
        vectors++; if (dut.state !== IDLE) begin errors++; $display("FAIL perf_rst_state got=%0d exp=%0d", dut.state, IDLE); end
        vectors++; if (perf_req_cnt !== '0 || perf_stall_cnt !== '0) begin errors++; $display("FAIL perf_rst_cnt got=%0d/%0d exp=0/0", perf_req_cnt, perf_stall_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_basic();
        test_flush_addr();
        test_flush_data();
        test_store_wait();
        test_done_hold();
`ifdef DATA_SRAM_CTRL_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
